// File: rtl/mac_seq_pkg.sv
// Shared defaults, FSM encoding and MAC latency for the sequential dot-product MAC.
package mac_seq_pkg;

    localparam int unsigned PR_DEF      = 8;
    localparam int unsigned BW_DEF      = 8;
    localparam int unsigned LW_DEF      = 4;
    localparam int unsigned BW_PSUM_DEF = 2 * BW_DEF + 3;
    localparam int unsigned BW_ACC_DEF  = BW_PSUM_DEF + LW_DEF;

    // Cycles from operand issue to registered lane sum.
    localparam int unsigned MAC_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_seq_mac.sv
// Two-stage pipelined pr-lane signed multiply-accumulate: products, then lane sum.
module mac
    import mac_seq_pkg::*;
#(
    parameter int unsigned pr      = PR_DEF,
    parameter int unsigned bw      = BW_DEF,
    parameter int unsigned bw_psum = 2 * bw + 3
) (
    input  logic                      clk,
    input  logic [pr*bw-1:0]          a,
    input  logic [pr*bw-1:0]          b,
    output logic signed [bw_psum-1:0] sum
);

    localparam int unsigned PW = 2 * bw;

    logic signed [PW-1:0]      prod_c [pr];
    logic signed [PW-1:0]      prod_q [pr];
    logic signed [bw_psum-1:0] sum_c;

    // Per-lane signed products.
    always_comb begin
        for (int unsigned i = 0; i < pr; i++) begin
            prod_c[i] = PW'($signed(a[i*bw +: bw])) * PW'($signed(b[i*bw +: bw]));
        end
    end

    // Stage 1: register the products.
    always_ff @(posedge clk) begin
        prod_q <= prod_c;
    end

    // Sign-extended reduction of the registered products.
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < pr; i++) begin
            sum_c = sum_c + bw_psum'(prod_q[i]);
        end
    end

    // Stage 2: register the lane sum.
    always_ff @(posedge clk) begin
        sum <= sum_c;
    end

endmodule

// File: rtl/mac_seq.sv
// Job controller: feeds len chunks through the pipelined MAC and accumulates a signed dot product.
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int unsigned pr      = PR_DEF,
    parameter int unsigned bw      = BW_DEF,
    parameter int unsigned bw_psum = 2 * bw + 3,
    parameter int unsigned lw      = LW_DEF,
    parameter int unsigned bw_acc  = bw_psum + lw
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [lw-1:0]     len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [pr*bw-1:0]  a_in,
    input  logic [pr*bw-1:0]  b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [bw_acc-1:0] out_data,
    output logic              busy
);

    state_t                    state, state_next;
    logic [lw-1:0]             cnt, cnt_next;
    logic [MAC_LAT-1:0]        tags, tags_next;
    logic signed [bw_acc-1:0]  acc, acc_next;
    logic                      accept_c;
    logic [pr*bw-1:0]          mac_a_c, mac_b_c;
    logic signed [bw_psum-1:0] mac_sum;

    assign accept_c = in_valid && in_ready;
    // Only accepted operands enter the MAC; idle cycles issue zeros.
    assign mac_a_c  = accept_c ? a_in : '0;
    assign mac_b_c  = accept_c ? b_in : '0;
    assign out_data = acc;

    mac #(
        .pr      (pr),
        .bw      (bw),
        .bw_psum (bw_psum)
    ) u_mac (
        .clk (clk),
        .a   (mac_a_c),
        .b   (mac_b_c),
        .sum (mac_sum)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, counter, tag pipeline and accumulator update.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        acc_next   = acc;
        tags_next  = {tags[MAC_LAT-2:0], accept_c};
        if (tags[MAC_LAT-1]) begin
            acc_next = acc + bw_acc'(mac_sum);
        end
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_next   = len;
                    acc_next   = '0;
                    state_next = (len == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                if (accept_c) begin
                    cnt_next = cnt - lw'(1);
                    if (cnt == lw'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Last in-flight sum is folded in this cycle when the tags empty next.
                if (tags_next == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            tags      <= '0;
            acc       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            tags      <= tags_next;
            acc       <= acc_next;
            in_ready  <= (state_next == FEED);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

endmodule
